// File: rtl/dmem_store_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_store_responder
// Purpose  : Word-addressed data RAM on the datapath store port. It contains a
//            pass/fail store checker and a 4-entry trace FIFO of accepted stores.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_store_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10000000,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] EXPECT_ADDR = 32'h10000054,
  parameter logic [31:0] EXPECT_DATA = 32'd64,
  parameter logic [31:0] IGNORE_ADDR = 32'h10000008,
  parameter int          TIMEOUT     = 1024
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        addr_err,
  output logic [15:0] store_count,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_ovf
);

  localparam int          c_aw      = $clog2(DEPTH);
  localparam logic [31:0] c_span    = 32'(4 * DEPTH);
  localparam logic [31:0] c_timeout = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t            r_state;
  logic [31:0]       r_cycles;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_faddr [4];
  logic [31:0]       r_fdata [4];
  logic [1:0]        r_wp;
  logic [1:0]        r_rp;
  logic [2:0]        r_fcnt;

  logic [31:0]       w_off;
  logic              w_inrange;
  logic [c_aw-1:0]   w_idx;
  logic              w_accept;
  logic              w_reject;
  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic [31:0]       w_cyc_next;

  always_comb begin
    w_off      = dataadr - BASE_ADDR;
    w_inrange  = (dataadr >= BASE_ADDR) && (w_off < c_span) && (dataadr[1:0] == 2'b00);
    w_idx      = w_off[c_aw+1:2];
    w_accept   = memwrite && w_inrange && !clear;
    w_reject   = memwrite && !w_inrange;
    w_pop      = trace_ready && (r_fcnt != 3'd0);
    w_full     = (r_fcnt == 3'd4);
    // A full FIFO still takes a push when the head leaves on the same edge.
    w_push     = w_accept && (!w_full || w_pop);
    w_cyc_next = r_cycles + 32'd1;
  end

  // RAM contents survive clear by design.
  always_ff @(posedge clock) begin
    if (w_accept)
      r_mem[w_idx] <= writedata;
  end

  assign readdata = w_inrange ? r_mem[w_idx] : 32'h0;

  always_ff @(posedge clock) begin
    if (clear)
      store_count <= 16'h0;
    else if (w_accept && (store_count != 16'hFFFF))
      store_count <= store_count + 16'h1;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= ST_RUN;
      r_cycles <= 32'h0;
      timeout  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (w_reject)
        addr_err <= 1'b1;
      if (r_state == ST_RUN) begin
        r_cycles <= w_cyc_next;
        // Any store that decides the verdict outranks a same-edge timeout.
        if (memwrite && (w_reject || (dataadr != IGNORE_ADDR))) begin
          if (!w_reject && (dataadr == EXPECT_ADDR) && (writedata == EXPECT_DATA))
            r_state <= ST_PASS;
          else
            r_state <= ST_FAIL;
        end else if (w_cyc_next == c_timeout) begin
          r_state <= ST_FAIL;
          timeout <= 1'b1;
        end
      end
    end
  end

  assign done = (r_state != ST_RUN);
  assign pass = (r_state == ST_PASS);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_wp      <= 2'd0;
      r_rp      <= 2'd0;
      r_fcnt    <= 3'd0;
      trace_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_faddr[r_wp] <= dataadr;
        r_fdata[r_wp] <= writedata;
        r_wp          <= r_wp + 2'd1;
      end
      if (w_pop)
        r_rp <= r_rp + 2'd1;
      if (w_push && !w_pop)
        r_fcnt <= r_fcnt + 3'd1;
      else if (!w_push && w_pop)
        r_fcnt <= r_fcnt - 3'd1;
      if (w_accept && !w_push)
        trace_ovf <= 1'b1;
    end
  end

  assign trace_valid = (r_fcnt != 3'd0);
  assign trace_addr  = trace_valid ? r_faddr[r_rp] : 32'h0;
  assign trace_data  = trace_valid ? r_fdata[r_rp] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_store_responder
// Purpose  : Scoreboard bench for dmem_store_responder: verdicts, RAM, trace FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_store_responder;

  logic        clock = 1'b0;
  logic        clear, memwrite, trace_ready;
  logic [31:0] dataadr, writedata;
  logic [31:0] readdata, trace_addr, trace_data;
  logic        done, pass, timeout, addr_err, trace_valid, trace_ovf;
  logic [15:0] store_count;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sbq [$];
  logic        exp_ovf;

  dmem_store_responder #(.TIMEOUT(16)) dut (
    .clock(clock), .clear(clear), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata), .done(done), .pass(pass),
    .timeout(timeout), .addr_err(addr_err), .store_count(store_count),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_ovf(trace_ovf)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= 32'h10000000) && (a < 32'h10000100) && (a[1:0] == 2'b00);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1; memwrite = 1'b0; trace_ready = 1'b0;
    dataadr = 32'h0; writedata = 32'h0;
    step();
    clear = 1'b0;
    sbq.delete();
    exp_ovf = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_done"},  done, 0);
    check({tag, "_pass"},  pass, 0);
    check({tag, "_tmo"},   timeout, 0);
    check({tag, "_aerr"},  addr_err, 0);
    check({tag, "_cnt"},   store_count, 0);
    check({tag, "_tv"},    trace_valid, 0);
    check({tag, "_taddr"}, trace_addr, 0);
    check({tag, "_tdata"}, trace_data, 0);
    check({tag, "_tovf"},  trace_ovf, 0);
  endtask

  // Drives one store for a cycle; the scoreboard follows push/pop of the FIFO.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] e;
    memwrite = 1'b1; dataadr = a; writedata = d;
    if (trace_ready && trace_valid) begin
      if (sbq.size() == 0) check("trace_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        check("trace_head", {trace_addr, trace_data}, e);
      end
    end
    if (in_range(a)) begin
      if (sbq.size() < 4) sbq.push_back({a, d});
      else exp_ovf = 1'b1;
    end
    step();
    memwrite = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [63:0] e;
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!trace_valid) break;
      if (sbq.size() == 0) check({tag, "_extra"}, {trace_addr, trace_data}, 0);
      else begin
        e = sbq.pop_front();
        check({tag, "_entry"}, {trace_addr, trace_data}, e);
      end
      step();
    end
    trace_ready = 1'b0;
    check({tag, "_left"}, sbq.size(), 0);
    check({tag, "_empty"}, trace_valid, 0);
  endtask

  initial begin
    do_reset();
    check_reset("rst");

    // Scratch store then verdict store: pass.
    store(32'h10000008, 32'd5);
    check("t1_notdone", done, 0);
    store(32'h10000054, 32'd64);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_cnt", store_count, 2);
    drain("t1");

    // Wrong verdict data; read-during-write returns old word.
    do_reset();
    store(32'h10000054, 32'd28);
    check("t2_done", done, 1);
    check("t2_pass", pass, 0);
    check("t2_tmo", timeout, 0);
    dataadr = 32'h10000054;
    #1 check("t2_rd", readdata, 28);
    memwrite = 1'b1; writedata = 32'd99;
    #1 check("t2_rd_old", readdata, 28);
    sbq.push_back({32'h10000054, 32'd99});
    step();
    memwrite = 1'b0;
    check("t2_rd_new", readdata, 99);
    drain("t2");

    // Stray store fails; later verdict store cannot rescue it.
    do_reset();
    store(32'h10000004, 32'd1);
    check("t3_done", done, 1);
    check("t3_pass", pass, 0);
    store(32'h10000054, 32'd64);
    check("t3_pass2", pass, 0);
    dataadr = 32'h10000054;
    #1 check("t3_rd", readdata, 64);
    drain("t3");

    // Rejected stores.
    do_reset();
    store(32'h10000055, 32'd7);
    store(32'h20000000, 32'd8);
    check("t4_aerr", addr_err, 1);
    check("t4_cnt", store_count, 0);
    check("t4_tv", trace_valid, 0);
    check("t4_done", done, 1);
    check("t4_pass", pass, 0);
    dataadr = 32'h10000055;
    #1 check("t4_rd_misal", readdata, 0);

    // FIFO overflow, then push+pop while full.
    do_reset();
    for (int i = 1; i <= 5; i++) store(32'h10000008, 32'(i));
    check("t5_ovf", trace_ovf, exp_ovf);
    check("t5_ovf1", trace_ovf, 1);
    check("t5_cnt", store_count, 5);
    check("t5_head", {trace_addr, trace_data}, {32'h10000008, 32'd1});
    trace_ready = 1'b1;
    store(32'h10000008, 32'd6);
    trace_ready = 1'b0;
    check("t5_head2", {trace_addr, trace_data}, {32'h10000008, 32'd2});
    check("t5_sbsize", sbq.size(), 4);
    check("t5_notdone", done, 0);
    drain("t5");

    // Timeout, then clear overriding a same-cycle store.
    do_reset();
    for (int i = 0; i < 15; i++) step();
    check("t6_early", done, 0);
    step();
    check("t6_done", done, 1);
    check("t6_tmo", timeout, 1);
    check("t6_pass", pass, 0);
    store(32'h10000054, 32'hAA);
    check("t6_cnt", store_count, 1);
    clear = 1'b1; memwrite = 1'b1; dataadr = 32'h10000054; writedata = 32'hBB;
    step();
    clear = 1'b0; memwrite = 1'b0;
    sbq.delete();
    check_reset("clr");
    #1 check("t6_rd_kept", readdata, 32'hAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
